// File: rtl/lsu_dmem_port_pkg.sv
// Shared definitions for the LSU data-memory port.
// Holds the RV32I load/store funct3 encodings, the response FSM state type
// and small legality helpers used by the port and its sub-modules.
package lsu_dmem_port_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no response outstanding
    ST_RESP = 2'd1,  // response presented, load data taken live from memory
    ST_HOLD = 2'd2   // response stalled, data served from the hold register
  } state_t;

  // Half-words need an even address, words a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  function automatic logic is_illegal_f3(input logic store, input logic [2:0] funct3);
    logic ill;
    if (store) begin
      ill = (funct3 >= 3'd3);
    end else begin
      ill = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    end
    return ill;
  endfunction

endpackage

// File: rtl/lsu_dmem_port_load_align.sv
// Combinational load extract/extend.
// Ports: rdata  - raw 32-bit memory word
//        offset - byte offset of the access within the word
//        funct3 - load type (LB/LH/LW/LBU/LHU)
//        data   - selected and sign/zero-extended result (0 for other funct3)
module lsu_load_align
  import lsu_dmem_port_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte/half and extend according to the load type.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h00_0000, byte_s};
      F3_HU:   data = {16'h0000, half_s};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_port.sv
// Initiator side of the synchronous data-memory port.
// Request side : req_valid/req_ready handshake with store flag, funct3,
//                byte address and low-aligned store data; flush kills the
//                outstanding response.
// Memory side  : addrD/renD/wenD/wdataD/MaskD driven combinationally in the
//                accept cycle; rdataD returns one cycle after renD.
// Response side: resp_valid/resp_ready with extended load data and an error
//                flag for misaligned or illegal accesses (which never reach
//                memory).
module lsu_dmem_port
  import lsu_dmem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addrD,
  output logic              renD,
  input  logic [DATA_W-1:0] rdataD,
  output logic              wenD,
  output logic [DATA_W-1:0] wdataD,
  output logic [3:0]        MaskD
);

  state_t            state_r, state_next_s;
  logic [2:0]        f3_r;
  logic [1:0]        off_r;
  logic              store_r;
  logic              err_r;
  logic [DATA_W-1:0] hold_data_r;

  logic              busy_s;
  logic              accept_s;
  logic              err_s;
  logic [DATA_W-1:0] align_s;
  logic [DATA_W-1:0] resp_data_s;

  assign busy_s    = (state_r == ST_RESP) || (state_r == ST_HOLD);
  // A new request may only enter when the current response leaves this cycle.
  assign req_ready = !reset && !flush && ((state_r == ST_IDLE) || (busy_s && resp_ready));
  assign accept_s  = req_valid && req_ready;
  assign err_s     = is_illegal_f3(req_store, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

  assign addrD = {req_addr[ADDR_W-1:2], 2'b00};
  assign renD  = accept_s && !req_store && !err_s;
  assign wenD  = accept_s && req_store && !err_s;

  // Store lane mask and data replication.
  always_comb begin
    MaskD  = 4'b0000;
    wdataD = {DATA_W{1'b0}};
    if (wenD) begin
      case (req_funct3[1:0])
        2'b00: begin
          MaskD  = 4'b0001 << req_addr[1:0];
          wdataD = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          MaskD  = req_addr[1] ? 4'b1100 : 4'b0011;
          wdataD = {2{req_wdata[15:0]}};
        end
        default: begin
          MaskD  = 4'b1111;
          wdataD = req_wdata;
        end
      endcase
    end else begin
      MaskD  = 4'b0000;
      wdataD = {DATA_W{1'b0}};
    end
  end

  lsu_load_align u_load_align (
    .rdata  (rdataD),
    .offset (off_r),
    .funct3 (f3_r),
    .data   (align_s)
  );

  // Stores and faulted accesses return zero data.
  assign resp_data_s = (store_r || err_r) ? {DATA_W{1'b0}} : align_s;

  // Response FSM next-state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RESP, ST_HOLD: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (resp_ready) begin
          state_next_s = accept_s ? ST_RESP : ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Response outputs: live data in RESP, held copy in HOLD.
  always_comb begin
    resp_valid = busy_s;
    resp_err   = busy_s && err_r;
    resp_rdata = {DATA_W{1'b0}};
    case (state_r)
      ST_RESP: resp_rdata = resp_data_s;
      ST_HOLD: resp_rdata = hold_data_r;
      default: resp_rdata = {DATA_W{1'b0}};
    endcase
  end

  // State, request attributes and stalled-response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      f3_r        <= 3'd0;
      off_r       <= 2'd0;
      store_r     <= 1'b0;
      err_r       <= 1'b0;
      hold_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        f3_r    <= req_funct3;
        off_r   <= req_addr[1:0];
        store_r <= req_store;
        err_r   <= err_s;
      end
      // rdataD is only valid for one cycle, so a stalled response is frozen here.
      if ((state_r == ST_RESP) && !resp_ready && !flush) begin
        hold_data_r <= resp_data_s;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
module tb_lsu_dmem_port;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        flush, resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, addrD, wdataD;
  logic [31:0] rdataD = 32'h0;
  logic        renD, wenD;
  logic [3:0]  MaskD;

  always #5 clk = ~clk;

  lsu_dmem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addrD(addrD), .renD(renD), .rdataD(rdataD), .wenD(wenD),
    .wdataD(wdataD), .MaskD(MaskD)
  );

  // Synchronous memory seen by the DUT: one-cycle read latency, byte-masked writes.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (renD) rdataD <= mem[addrD[9:2]];
    if (wenD) begin
      for (int i = 0; i < 4; i++) begin
        if (MaskD[i]) mem[addrD[9:2]][8*i +: 8] <= wdataD[8*i +: 8];
      end
    end
  end

  // Reference model: byte-addressed memory plus one pending expected response.
  logic [7:0]  ref_mem [0:1023];
  bit          pending;
  logic [31:0] exp_rdata;
  bit          exp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_rdata, obs_wdata;
  logic        obs_valid, obs_err, obs_ready, obs_ren, obs_wen;
  logic [3:0]  obs_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit legal_f3(input bit st, input logic [2:0] f3);
    if (st) return (f3 <= 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  // One clock: drive inputs, check against the model, then advance the model.
  task automatic do_cycle(input bit v, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit rr, input bit fl, input bit rs);
    int          sz;
    bit          bad, pred_ready, acc, mem_rd, mem_wr;
    logic [3:0]  e_mask;
    logic [31:0] e_wd, val;
    @(negedge clk);
    reset = rs; req_valid = v; req_store = st; req_funct3 = f3; req_addr = a;
    req_wdata = wd; resp_ready = rr; flush = fl;
    #1;
    sz         = size_of(f3);
    bad        = !legal_f3(st, f3) || ((a % sz) != 0);
    pred_ready = !rs && !fl && (!pending || rr);
    acc        = v && pred_ready;
    mem_rd     = acc && !st && !bad;
    mem_wr     = acc && st && !bad;
    e_mask = 4'b0000;
    e_wd   = 32'h0;
    if (mem_wr) begin
      for (int i = 0; i < sz; i++) e_mask[(a % 4) + i] = 1'b1;
      for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = wd[8*(l % sz) +: 8];
    end
    check_val("req_ready", req_ready, pred_ready);
    check_val("renD", renD, mem_rd);
    check_val("wenD", wenD, mem_wr);
    check_val("MaskD", MaskD, e_mask);
    if (mem_wr) check_val("wdataD", wdataD, e_wd);
    if (mem_rd || mem_wr) check_val("addrD", addrD, a & 32'hFFFF_FFFC);
    if (!rs) begin
      check_val("resp_valid", resp_valid, pending);
      if (pending) begin
        check_val("resp_rdata", resp_rdata, exp_rdata);
        check_val("resp_err", resp_err, exp_err);
      end
    end
    obs_rdata = resp_rdata; obs_valid = resp_valid; obs_err = resp_err; obs_ready = req_ready;
    obs_ren = renD; obs_wen = wenD; obs_mask = MaskD; obs_wdata = wdataD;
    if (rs) begin
      pending = 1'b0;
    end else begin
      if (pending && (fl || rr)) pending = 1'b0;
      if (acc) begin
        pending   = 1'b1;
        exp_err   = bad;
        exp_rdata = 32'h0;
        if (mem_wr) begin
          for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else if (mem_rd) begin
          val = 32'h0;
          for (int i = 0; i < sz; i++) val = val | (32'(ref_mem[a + i]) << (8 * i));
          if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | ~((32'h1 << (8 * sz)) - 32'h1);
          exp_rdata = val;
        end
      end
    end
  endtask

  task automatic idle(input bit rr);
    do_cycle(1'b0, 1'b0, 3'd0, 32'h100, 32'h0, rr, 1'b0, 1'b0);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    do_cycle(1'b1, 1'b0, f3, a, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check_val({tag, "_valid"}, obs_valid, 32'h1);
    check_val(tag, obs_rdata, exp);
    check_val({tag, "_err"}, obs_err, 32'h0);
  endtask

  task automatic err_chk(input string tag, input bit st, input logic [2:0] f3, input logic [31:0] a);
    do_cycle(1'b1, st, f3, a, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0);
    check_val({tag, "_mem"}, {30'h0, obs_ren, obs_wen}, 32'h0);
    idle(1'b1);
    check_val({tag, "_err"}, obs_err, 32'h1);
    check_val({tag, "_rdata"}, obs_rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    pending = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (i == 64) w = 32'h80F1_7F23;
      if (i == 65) w = 32'h1234_5678;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; flush = 1'b0;

    do_cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check_val("rst_valid", obs_valid, 32'h0);
    check_val("rst_rdata", obs_rdata, 32'h0);
    check_val("rst_err", obs_err, 32'h0);
    check_val("rst_mask", obs_mask, 32'h0);

    load_chk("lb101", 3'd0, 32'h101, 32'h0000_007F);
    load_chk("lb103", 3'd0, 32'h103, 32'hFFFF_FF80);
    load_chk("lbu103", 3'd4, 32'h103, 32'h0000_0080);
    load_chk("lh102", 3'd1, 32'h102, 32'hFFFF_80F1);
    load_chk("lhu100", 3'd5, 32'h100, 32'h0000_7F23);

    do_cycle(1'b1, 1'b1, 3'd0, 32'h102, 32'h0000_00AB, 1'b1, 1'b0, 1'b0);
    check_val("sb_wen", obs_wen, 32'h1);
    check_val("sb_mask", obs_mask, 32'h4);
    check_val("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    load_chk("lw_after_sb", 3'd2, 32'h100, 32'h80AB_7F23);
    do_cycle(1'b1, 1'b1, 3'd0, 32'h102, 32'h0000_00F1, 1'b1, 1'b0, 1'b0);

    err_chk("sh101", 1'b1, 3'd1, 32'h101);
    err_chk("lw102", 1'b0, 3'd2, 32'h102);
    err_chk("ld_f3_3", 1'b0, 3'd3, 32'h100);
    load_chk("lw_unchanged", 3'd2, 32'h100, 32'h80F1_7F23);

    // Stalled response held for three cycles, then back-to-back LW 0x104.
    do_cycle(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 1'b0, 1'b0, 1'b0);
      check_val("hold_rdata", obs_rdata, 32'h80F1_7F23);
      check_val("hold_ready", obs_ready, 32'h0);
      check_val("hold_ren", obs_ren, 32'h0);
    end
    do_cycle(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("b2b_ren", obs_ren, 32'h1);
    idle(1'b1);
    check_val("b2b_valid", obs_valid, 32'h1);
    check_val("b2b_rdata", obs_rdata, 32'h1234_5678);

    // Flush while holding.
    do_cycle(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    do_cycle(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    check_val("flush_ready", obs_ready, 32'h0);
    idle(1'b1);
    check_val("flush_valid", obs_valid, 32'h0);

    // Reset right after a load accept.
    do_cycle(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_val("rst_mid_valid", obs_valid, 32'h0);
    check_val("rst_mid_ren", obs_ren, 32'h0);
    load_chk("lb_after_rst", 3'd0, 32'h101, 32'h0000_007F);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      do_cycle(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 31)), $urandom,
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
